// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: state encoding,
// default sizing and the load-use detect.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hsu_state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 64;

    // x0 is hardwired zero, so a load "into" it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable,
    output logic [width-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: memory-wait freeze with timeout, load-use bubble,
// taken-branch flush, and a stall-cycle performance counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; load-use / branch hazards resolved here
//   MEM_WAIT | data memory access outstanding, whole pipeline frozen
//   ERROR    | memory never acknowledged; frozen until reset
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_Rs1_in,
    input  logic [4:0]       ID_Rs2_in,
    input  logic             EX_MemRead_in,
    input  logic [4:0]       EX_Rd_in,
    input  logic             MEM_MemReq_in,
    input  logic             MEM_Ack_in,
    input  logic             Branch_Taken_in,
    output logic             PC_Write_out,
    output logic             IFID_Write_out,
    output logic             IDEX_Bubble_out,
    output logic             IFID_Flush_out,
    output logic             Pipe_Freeze_out,
    output logic             Mem_Error_out,
    output logic [CNT_W-1:0] Stall_Count_out
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

    hsu_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_freeze;

    // The counter lands on MEM_TIMEOUT-1 on the same edge that enters ERROR,
    // so the error flag rises after MEM_TIMEOUT frozen cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (MEM_MemReq_in && !MEM_Ack_in) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (MEM_Ack_in) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state <= ERROR;
                        end
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        load_use        = load_use_hazard(EX_MemRead_in, EX_Rd_in, ID_Rs1_in, ID_Rs2_in);
        mem_freeze      = 1'b0;
        PC_Write_out    = 1'b1;
        IFID_Write_out  = 1'b1;
        IDEX_Bubble_out = 1'b0;
        IFID_Flush_out  = 1'b0;

        case (state)
            ERROR:    mem_freeze = 1'b1;
            MEM_WAIT: mem_freeze = !MEM_Ack_in;
            default:  mem_freeze = MEM_MemReq_in && !MEM_Ack_in;
        endcase

        // Outputs are forced to the free-running pattern while reset is held.
        if (!rst_i) begin
            mem_freeze = 1'b0;
        end else if (mem_freeze) begin
            PC_Write_out   = 1'b0;
            IFID_Write_out = 1'b0;
        end else if (load_use) begin
            PC_Write_out    = 1'b0;
            IFID_Write_out  = 1'b0;
            IDEX_Bubble_out = 1'b1;
        end else if (Branch_Taken_in) begin
            IFID_Flush_out = 1'b1;
        end
    end

    assign Pipe_Freeze_out = mem_freeze;
    assign Mem_Error_out   = (state == ERROR);

    sat_counter #(
        .width (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .enable (!PC_Write_out),
        .count  (Stall_Count_out)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: expected outputs per cycle are queued
// with the stimulus and compared when the cycle's outputs settle.
module tb_hazard_stall_unit;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    // {pc_write, ifid_write, bubble, flush, freeze, mem_error}
    localparam logic [5:0] O_IDLE  = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b001000;
    localparam logic [5:0] O_FLUSH = 6'b110100;
    localparam logic [5:0] O_FRZ   = 6'b000010;
    localparam logic [5:0] O_ERR   = 6'b000011;

    typedef struct {
        string      tag;
        logic [5:0] outs;
        int         cnt;
    } exp_t;

    logic             clk_i;
    logic             rst_i;
    logic [4:0]       ID_Rs1_in;
    logic [4:0]       ID_Rs2_in;
    logic             EX_MemRead_in;
    logic [4:0]       EX_Rd_in;
    logic             MEM_MemReq_in;
    logic             MEM_Ack_in;
    logic             Branch_Taken_in;
    logic             PC_Write_out;
    logic             IFID_Write_out;
    logic             IDEX_Bubble_out;
    logic             IFID_Flush_out;
    logic             Pipe_Freeze_out;
    logic             Mem_Error_out;
    logic [CNT_W-1:0] Stall_Count_out;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_stall_unit #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ID_Rs1_in       (ID_Rs1_in),
        .ID_Rs2_in       (ID_Rs2_in),
        .EX_MemRead_in   (EX_MemRead_in),
        .EX_Rd_in        (EX_Rd_in),
        .MEM_MemReq_in   (MEM_MemReq_in),
        .MEM_Ack_in      (MEM_Ack_in),
        .Branch_Taken_in (Branch_Taken_in),
        .PC_Write_out    (PC_Write_out),
        .IFID_Write_out  (IFID_Write_out),
        .IDEX_Bubble_out (IDEX_Bubble_out),
        .IFID_Flush_out  (IFID_Flush_out),
        .Pipe_Freeze_out (Pipe_Freeze_out),
        .Mem_Error_out   (Mem_Error_out),
        .Stall_Count_out (Stall_Count_out)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [5:0] e);
        chk({tag, ".pc_write"}, int'(PC_Write_out),    int'(e[5]));
        chk({tag, ".ifid_wr"},  int'(IFID_Write_out),  int'(e[4]));
        chk({tag, ".bubble"},   int'(IDEX_Bubble_out), int'(e[3]));
        chk({tag, ".flush"},    int'(IFID_Flush_out),  int'(e[2]));
        chk({tag, ".freeze"},   int'(Pipe_Freeze_out), int'(e[1]));
        chk({tag, ".mem_err"},  int'(Mem_Error_out),   int'(e[0]));
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic memrd, input logic req, input logic ack, input logic br);
        ID_Rs1_in       = rs1;
        ID_Rs2_in       = rs2;
        EX_Rd_in        = rd;
        EX_MemRead_in   = memrd;
        MEM_MemReq_in   = req;
        MEM_Ack_in      = ack;
        Branch_Taken_in = br;
    endtask

    // Called just after a rising edge; covers exactly one clock cycle.
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic memrd, input logic req,
                        input logic ack, input logic br, input logic [5:0] eo, input int ecnt);
        exp_t e;
        drive(rs1, rs2, rd, memrd, req, ack, br);
        e.tag  = tag;
        e.outs = eo;
        e.cnt  = ecnt;
        sb.push_back(e);
        @(negedge clk_i);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk_outs(e.tag, e.outs);
            @(posedge clk_i);
            #1;
            chk({e.tag, ".stall_cnt"}, int'(Stall_Count_out), e.cnt);
        end
    endtask

    task automatic idle(input string tag, input int ecnt);
        step(tag, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, ecnt);
    endtask

    // Reset is applied mid-cycle with every hazard input active.
    task automatic do_reset(input string tag);
        @(negedge clk_i);
        drive(5'd3, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        rst_i = 1'b0;
        #1;
        chk_outs({tag, ".rst"}, O_IDLE);
        chk({tag, ".rst.stall_cnt"}, int'(Stall_Count_out), 0);
        @(negedge clk_i);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);

        // Basic hazard decode and priority
        do_reset("init");
        idle("idle0", 0);
        step("lu_rs2",   5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL, 1);
        idle("idle1", 1);
        step("lu_x0",    5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, 1);
        step("lu_rs1",   5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL, 2);
        step("no_load",  5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2);
        step("lu_br",    5'd6, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, O_STALL, 3);
        step("br_only",  5'd6, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, O_FLUSH, 3);
        step("req_ack",  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_IDLE, 3);
        step("lu_br_req", 5'd6, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, O_FRZ, 4);
        step("wait_ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_IDLE, 4);
        idle("idle2", 4);

        // Acknowledge three cycles after the request
        do_reset("ack3");
        for (int i = 0; i < 3; i++) begin
            step($sformatf("ack3.frz%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ, i + 1);
        end
        step("ack3.ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_IDLE, 3);
        idle("ack3.idle", 3);

        // Timeout into ERROR, which ignores everything but reset
        do_reset("tmo");
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            step($sformatf("tmo.frz%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ, i + 1);
        end
        step("tmo.err0", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_ERR, 5);
        step("tmo.err1", 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, O_ERR, 6);
        step("tmo.err2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_ERR, 7);
        do_reset("tmo_clr");
        idle("tmo_clr.idle", 0);

        // Reset asserted mid-wait
        do_reset("mid");
        step("mid.frz0", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ, 1);
        step("mid.frz1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ, 2);
        do_reset("mid_rst");
        idle("mid.idle", 0);
        step("mid.req", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ, 1);
        step("mid.ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE, 1);

        // Stall counter saturation
        do_reset("sat");
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat.%0d", i), 5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL,
                 (i + 1 > 15) ? 15 : i + 1);
        end
        idle("sat.hold", 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 64: maximum number of cycles to wait for a memory acknowledge.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset; asynchronous, active-low.
REQ-005 ID_Rs1_in, ID_Rs2_in  in  5 each  source registers of the instruction in ID.
REQ-006 EX_MemRead_in  in  1  instruction in EX is a load.
REQ-007 EX_Rd_in  in  5  destination register of the instruction in EX.
REQ-008 MEM_MemReq_in  in  1  instruction in MEM accesses data memory.
REQ-009 MEM_Ack_in  in  1  data memory access completes this cycle.
REQ-010 Branch_Taken_in  in  1  branch resolved taken in ID.
REQ-011 PC_Write_out  out  1  PC update enable.
REQ-012 IFID_Write_out  out  1  IF/ID register enable.
REQ-013 IDEX_Bubble_out  out  1  inject NOP into ID/EX.
REQ-014 IFID_Flush_out  out  1  clear IF/ID.
REQ-015 Pipe_Freeze_out  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-016 Mem_Error_out  out  1  sticky memory-timeout flag.
REQ-017 Stall_Count_out  out  CNT_W  stall cycles since reset.

Function
REQ-018 The FSM SHALL have states RUN, MEM_WAIT and ERROR; the outputs SHALL be decoded combinationally from the current state and inputs.
REQ-019 Load-use hazard = EX_MemRead_in && EX_Rd_in!=0 && (EX_Rd_in==ID_Rs1_in || EX_Rd_in==ID_Rs2_in).
REQ-020 In RUN, with MEM_MemReq_in=1 and MEM_Ack_in=0, the block SHALL assert Pipe_Freeze_out=1, PC_Write_out=0 and IFID_Write_out=0, and SHALL move to MEM_WAIT.
REQ-021 In RUN, with MEM_MemReq_in && MEM_Ack_in, the block SHALL raise no freeze; the access completes in one cycle.
REQ-022 In MEM_WAIT, the freeze outputs of REQ-020 SHALL stay asserted until the cycle in which MEM_Ack_in=1.
REQ-023 In the acknowledge cycle, the freeze outputs SHALL deassert and the FSM SHALL return to RUN (zero-cycle release).
REQ-024 In MEM_WAIT, a wait counter SHALL increment each cycle and SHALL be cleared on entry to MEM_WAIT.
REQ-025 When the wait counter reaches MEM_TIMEOUT-1 with no acknowledge, the FSM SHALL move to ERROR.
REQ-026 ERROR SHALL be terminal until reset: Mem_Error_out=1, freeze outputs asserted, all other hazard logic ignored.
REQ-027 In RUN, with no memory freeze and a load-use hazard: PC_Write_out=0, IFID_Write_out=0, IDEX_Bubble_out=1 for exactly that cycle.
REQ-028 During a load-use stall, Branch_Taken_in SHALL be ignored (IFID_Flush_out=0), because the branch operands are not yet valid.
REQ-029 In RUN, with no freeze, no load-use hazard and Branch_Taken_in=1: IFID_Flush_out=1 and PC_Write_out=1.
REQ-030 Priority SHALL be: ERROR > memory freeze > load-use stall > branch flush.
REQ-031 While a freeze is active, IDEX_Bubble_out and IFID_Flush_out SHALL be 0.
REQ-032 Stall_Count_out SHALL increment in every cycle with PC_Write_out=0 and SHALL saturate at all-ones, with no wrap-around.
REQ-033 With no hazard: PC_Write_out=1, IFID_Write_out=1, all other outputs 0.

Reset
REQ-034 While rst_i=0, the FSM SHALL be RUN, the wait counter 0, Stall_Count_out 0 and Mem_Error_out 0, regardless of the clock.
REQ-035 During reset, outputs SHALL be PC_Write_out=1, IFID_Write_out=1, IDEX_Bubble_out=0, IFID_Flush_out=0, Pipe_Freeze_out=0.
REQ-036 Reset asserted in MEM_WAIT or ERROR SHALL abandon the wait immediately and restart in RUN.

Structure
REQ-037 The state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2) and the default parameter values SHALL reside in a shared pipeline package.
REQ-038 The saturating counter SHALL be one sub-module, sat_counter (parameter width; ports enable, count), used for Stall_Count_out.

Verification
REQ-039 EX_MemRead_in=1, EX_Rd_in=5, ID_Rs2_in=5 for one cycle -> that cycle PC_Write_out=0, IDEX_Bubble_out=1; Stall_Count_out=1 afterwards.
REQ-040 Load-use with EX_Rd_in=0 and ID_Rs1_in=0 -> no stall, Stall_Count_out unchanged.
REQ-041 MEM_MemReq_in=1 with MEM_Ack_in arriving 3 cycles later -> Pipe_Freeze_out=1 for 3 cycles, 0 in the acknowledge cycle; Stall_Count_out=3.
REQ-042 Load-use hazard plus Branch_Taken_in=1 in the same cycle -> IDEX_Bubble_out=1, IFID_Flush_out=0; MEM_MemReq_in added in that cycle -> freeze only, bubble 0.
REQ-043 MEM_MemReq_in with no acknowledge and MEM_TIMEOUT=4 -> Mem_Error_out=1 after 4 cycles and held; rst_i pulsed low mid-wait instead -> immediate RUN with counters 0.
REQ-044 CNT_W=4 with 20 stall cycles -> Stall_Count_out holds at 15.
